// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller slice.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 1;
  localparam int DEF_DATA_W = 8;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP,
    FILL,
    VRD_ADDR,
    VRD_CAP
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Host-side request/response/fill channel of the RAM access controller.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 8
);
  // A request transfers on a rising edge where req_valid and req_ready are both 1;
  // the master holds req_we/req_addr/req_wdata stable while req_valid waits for ready.
  // rsp_valid is an unconditional one-cycle pulse with no back-pressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, fill_start, fill_value,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, fill_start, fill_value,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_fill_counter.sv
// Address counter for the fill sweep: restart, advance, terminal count at the top address.
module ram_fill_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = en && (&count);

  // Returns to 0 on the last step so the next fill begins at address 0.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer for a single-port RAM: valid/ready requests, read-response pulse, hardware fill.
// Optional write readback check enabled by defining RAM_ACCESS_CTRL_VERIFY_EN.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clear,
  ram_access_ctrl_if.slave  host,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_r_w,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  output logic              verify_err,
`endif
  output state_t            dbg_state
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [ADDR_W-1:0] fill_cnt;
  logic              fill_tc;
  logic              fill_go;
  logic              fill_en;
  logic              accept;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (fill_go)     state_nx = FILL;
        else if (accept) state_nx = (host.req_we == OP_WR) ? WR : RD_ADDR;
      end
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      WR:       state_nx = VRD_ADDR;
      VRD_ADDR: state_nx = VRD_CAP;
      VRD_CAP:  state_nx = IDLE;
`else
      WR:       state_nx = IDLE;
`endif
      RD_ADDR:  state_nx = RD_CAP;
      RD_CAP:   state_nx = IDLE;
      FILL:     if (fill_tc) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Fill wins over a simultaneous request, which simply sees req_ready low.
  always_comb begin
    fill_go        = (state == IDLE) && host.fill_start;
    host.req_ready = clear && (state == IDLE) && !host.fill_start;
    accept         = host.req_valid && host.req_ready;
    fill_en        = (state == FILL);
    ram_r_w        = (state == WR) || (state == FILL);
    ram_addr       = fill_en ? fill_cnt : addr_q;
    ram_din        = din_q;
    busy           = (state != IDLE);
  end

  // din_q only changes on a write or fill launch, so ram_din holds between operations.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= (state == RD_CAP);
      if (state == RD_CAP) rsp_rdata_q <= ram_dout;
      if (fill_go) begin
        din_q <= host.fill_value;
      end else if (accept) begin
        addr_q <= host.req_addr;
        if (host.req_we == OP_WR) din_q <= host.req_wdata;
      end
    end
  end

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)                                    verify_err <= 1'b0;
    else if (state == VRD_CAP && ram_dout != din_q) verify_err <= 1'b1;
  end
`endif

  ram_fill_counter #(.W(ADDR_W)) u_fill_cnt (
    .clk   (clk),
    .clear (clear),
    .start (fill_go),
    .en    (fill_en),
    .count (fill_cnt),
    .tc    (fill_tc)
  );

  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: transaction-level timing model with per-cycle compare plus literal checks.
module tb_ram_access_ctrl;
  import ram_ctrl_pkg::*;

  localparam int AW = 1;
  localparam int DW = 8;
  localparam int D  = 2 ** AW;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  localparam int WLAT = 4;
`else
  localparam int WLAT = 2;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) host ();
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_r_w;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  state_t        dbg_state;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  logic          verify_err;
`endif

  ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .clear     (clear),
    .host      (host),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_r_w   (ram_r_w),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    .verify_err(verify_err),
`endif
    .dbg_state (dbg_state)
  );

  // RAM array: synchronous write, registered read, optional bit-0 stuck-at-0 on readout
  logic [DW-1:0] ram_mem [D];
  bit            stuck_en = 1'b0;
  int            n_wr = 0;
  initial foreach (ram_mem[i]) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_r_w) begin
      ram_mem[ram_addr] <= ram_din;
      n_wr <= n_wr + 1;
    end
    ram_dout <= ram_mem[ram_addr] & (stuck_en ? {{(DW-1){1'b1}}, 1'b0} : {DW{1'b1}});
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int            at;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           wr_q[$];
  ev_t           exp_q[$];
  logic [DW-1:0] ref_mem [D];
  int            free_cyc = 0;
  int            err_at = 32'h7fffffff;
  bit            in_rst = 1'b1;
  initial foreach (ref_mem[i]) ref_mem[i] = '0;

  // Model: a request occupies the controller for a fixed number of cycles;
  // writes land the cycle after acceptance, reads answer three cycles after.
  always @(negedge clk) begin : compare
    bit idle, exp_w, exp_r;
    if (!clear) begin
      in_rst = 1'b1;
      wr_q.delete();
      exp_q.delete();
      err_at = 32'h7fffffff;
      check("rst_req_ready", host.req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_ram_r_w", ram_r_w, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_rsp_valid", host.rsp_valid, 0);
      check("rst_rsp_rdata", host.rsp_rdata, 0);
    end else begin
      if (in_rst) begin
        in_rst = 1'b0;
        free_cyc = cyc;
      end
      idle = (cyc >= free_cyc);
      check("req_ready", host.req_ready, idle && !host.fill_start);
      check("busy", busy, !idle);

      exp_w = (wr_q.size() > 0) && (wr_q[0].at == cyc);
      check("ram_r_w", ram_r_w, exp_w);
      if (exp_w && ram_r_w) begin
        check("ram_addr", ram_addr, wr_q[0].addr);
        check("ram_din", ram_din, wr_q[0].data);
      end
      while (wr_q.size() > 0 && wr_q[0].at <= cyc) void'(wr_q.pop_front());

      exp_r = (exp_q.size() > 0) && (exp_q[0].at == cyc);
      check("rsp_valid", host.rsp_valid, exp_r);
      if (exp_r && host.rsp_valid) check("rsp_rdata", host.rsp_rdata, exp_q[0].data);
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) void'(exp_q.pop_front());

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      check("verify_err", verify_err, cyc >= err_at);
`endif

      if (idle && host.fill_start) begin
        for (int i = 0; i < D; i++) begin
          wr_q.push_back('{cyc + 1 + i, AW'(i), host.fill_value});
          ref_mem[i] = host.fill_value;
        end
        free_cyc = cyc + D + 1;
      end else if (idle && host.req_valid) begin
        if (host.req_we) begin
          wr_q.push_back('{cyc + 1, host.req_addr, host.req_wdata});
          ref_mem[host.req_addr] = host.req_wdata;
          free_cyc = cyc + WLAT;
          if (stuck_en && host.req_wdata[0] && err_at > cyc + 4) err_at = cyc + 4;
        end else begin
          exp_q.push_back('{cyc + 3, host.req_addr, ref_mem[host.req_addr]});
          free_cyc = cyc + 3;
        end
      end
    end
  end

  // driver tasks (each starts and ends 1 time unit after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_addr  = a;
    host.req_wdata = d;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host.req_ready) begin
        acc = cyc;
        break;
      end
    end
    tick();
    host.req_valid = 1'b0;
    if (acc < 0) check("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int acc, output logic [DW-1:0] d, output int lat);
    bit got = 1'b0;
    d = '0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (host.rsp_valid) begin
        got = 1'b1;
        d = host.rsp_rdata;
        lat = cyc - acc;
        break;
      end
    end
    tick();
    if (!got) check("rsp_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    int acc;
    do_req(1'b0, a, '0, acc);
    wait_rsp(acc, d, lat);
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int            acc, lat, fc, bc, w0, pulses;
    logic [DW-1:0] d;
    vec_t          vecs[9];

    host.req_valid  = 1'b1;
    host.req_we     = 1'b1;
    host.req_addr   = 1;
    host.req_wdata  = 8'hFF;
    host.fill_start = 1'b0;
    host.fill_value = '0;

    // reset held with a pending request: nothing may move
    repeat (3) @(negedge clk);
    check("lit_rst_n_wr", n_wr, 0);
    check("lit_rst_ready", host.req_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    host.req_valid = 1'b0;
    @(negedge clk);
    check("lit_ready_after_release", host.req_ready, 1);
    tick();

    // write then read back
    w0 = n_wr;
    do_req(1'b1, 1, 8'hA5, acc);
    do_read(1, d, lat);
    check("lit_wr_count", n_wr - w0, 1);
    check("lit_rd_a5", d, 8'hA5);
    check("lit_rd_latency", lat, 3);

    do_req(1'b1, 0, 8'h11, acc);
    do_read(0, d, lat);
    check("lit_rd_11", d, 8'h11);
    do_read(1, d, lat);
    check("lit_rd_a5_again", d, 8'hA5);

    // fill
    w0 = n_wr;
    host.fill_value = 8'h3C;
    host.fill_start = 1'b1;
    tick();
    host.fill_start = 1'b0;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    tick();
    check("lit_fill_busy_cycles", bc, D);
    check("lit_fill_wr_count", n_wr - w0, D);
    do_read(0, d, lat);
    check("lit_fill_rd0", d, 8'h3C);
    do_read(1, d, lat);
    check("lit_fill_rd1", d, 8'h3C);

    // fill and request together: fill first, request stalls
    host.fill_value = 8'h77;
    host.fill_start = 1'b1;
    host.req_valid  = 1'b1;
    host.req_we     = 1'b0;
    host.req_addr   = 0;
    @(negedge clk);
    fc = cyc;
    check("lit_prio_ready", host.req_ready, 0);
    tick();
    host.fill_start = 1'b0;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host.req_ready) begin
        acc = cyc;
        break;
      end
    end
    tick();
    host.req_valid = 1'b0;
    check("lit_prio_accept_cycle", acc - fc, D + 1);
    wait_rsp(acc, d, lat);
    check("lit_prio_rd", d, 8'h77);

    // abort a read in RD_ADDR
    do_req(1'b1, 0, 8'h5A, acc);
    do_req(1'b0, 1, '0, acc);
    clear = 1'b0;
    #1;
    check("lit_abort_state", dbg_state, IDLE);
    tick();
    tick();
    clear = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host.rsp_valid) pulses++;
    end
    tick();
    check("lit_abort_no_rsp", pulses, 0);
    do_read(0, d, lat);
    check("lit_abort_rd_5a", d, 8'h5A);

    // directed back-to-back vectors; reads checked by the model
    vecs[0] = '{1'b1, 0, 8'hC3};
    vecs[1] = '{1'b0, 0, 8'h00};
    vecs[2] = '{1'b0, 1, 8'h00};
    vecs[3] = '{1'b1, 1, 8'h00};
    vecs[4] = '{1'b0, 1, 8'h00};
    vecs[5] = '{1'b1, 0, 8'hFF};
    vecs[6] = '{1'b1, 1, 8'h81};
    vecs[7] = '{1'b0, 0, 8'h00};
    vecs[8] = '{1'b0, 1, 8'h00};
    foreach (vecs[i]) begin
      if (vecs[i].we) do_req(1'b1, vecs[i].addr, vecs[i].data, acc);
      else            do_read(vecs[i].addr, d, lat);
    end
    check("lit_vec_rd1_81", d, 8'h81);

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    // readback with a stuck bit: sticky error until reset
    do_req(1'b1, 0, 8'h02, acc);
    repeat (4) tick();
    check("lit_verify_clean", verify_err, 0);
    stuck_en = 1'b1;
    do_req(1'b1, 1, 8'hFF, acc);
    repeat (6) tick();
    check("lit_verify_err_set", verify_err, 1);
    repeat (5) tick();
    check("lit_verify_err_sticky", verify_err, 1);
    clear = 1'b0;
    tick();
    stuck_en = 1'b0;
    clear = 1'b1;
    tick();
    check("lit_verify_err_cleared", verify_err, 0);
`endif

    repeat (4) tick();
    check("wr_queue_drained", wr_q.size(), 0);
    check("rsp_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Initiator-side sequencer that drives the raw RAM port: `ram_addr`, `ram_r_w`, `ram_din`, `ram_dout`.
- Exposes a valid/ready request channel and a one-cycle read-response pulse to the rest of the design.
- Adds a hardware fill operation that writes one value to every address.
- Sits between the datapath/controller and the 1x8-class RAM arrays.

Parameters:
- ADDR_W, 1, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM word width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clear  input  1  reset, asynchronous, active-low.
- req_valid  input  1  host request present.
- req_ready  output  1  controller accepts a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  output  DATA_W  read data.
- fill_start  input  1  begin fill of whole RAM.
- fill_value  input  DATA_W  word written by fill.
- busy  output  1  high in any state other than IDLE.
- ram_addr  output  ADDR_W  RAM address.
- ram_r_w  output  1  1 = write on next clk edge, 0 = read.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data; valid one cycle after ram_addr is applied with ram_r_w = 0.

Behaviour:
- Reset (clear low, asynchronous): state IDLE.
  - All outputs 0: rsp_valid, rsp_rdata, busy, ram_addr, ram_r_w, ram_din.
  - req_ready = 0 while clear is low; it is 1 in the first IDLE cycle after release.
  - Fill counter = 0.
- Reset mid-operation aborts immediately. A partial fill leaves earlier words written. No rsp_valid is issued for the aborted read.
- States: IDLE, WR, RD_ADDR, RD_CAP, FILL.
- IDLE:
  - req_ready = !fill_start.
  - fill_start = 1: go to FILL, latch fill_value, counter = 0. fill_start has priority over req_valid.
  - Otherwise, req_valid & req_ready: register addr/wdata/we, then go to WR (we = 1) or RD_ADDR (we = 0).
- WR: one cycle with ram_r_w = 1, ram_addr and ram_din = the latched values; then IDLE. Write latency: 2 cycles from accept to the next accept.
- RD_ADDR: ram_r_w = 0, ram_addr = latched address; then RD_CAP.
- RD_CAP:
  - rsp_rdata <= ram_dout; rsp_valid = 1 for exactly one cycle (registered, asserted in the cycle after RD_CAP).
  - Then IDLE.
  - Read latency: accept at cycle N → rsp_valid at N+3. rsp_rdata holds its value until the next read.
- FILL:
  - ram_r_w = 1, ram_addr = counter, ram_din = latched fill_value.
  - Counter increments each cycle.
  - On counter == 2**ADDR_W−1, the write completes that cycle, then IDLE. No wrap: the counter resets to 0 on exit.
  - Fill takes exactly 2**ADDR_W cycles.
  - req_valid and fill_start are ignored during FILL (req_ready = 0).
- Outside WR/FILL: ram_r_w = 0, so no spurious write ever occurs. ram_din holds its last value.
- busy = (state != IDLE).
- Back-to-back requests are legal; there is no pipelining, one request in flight at a time.

Optional Feature:
- Macro: RAM_ACCESS_CTRL_VERIFY_EN.
- Defined:
  - Every WR is followed by a readback: WR → VRD_ADDR → VRD_CAP → IDLE.
  - VRD_CAP compares ram_dout with the written data. On mismatch, it sets sticky output `verify_err` (1 bit, cleared only by reset).
  - Write latency becomes 4 cycles.
  - FILL does not verify.
- Undefined: no verify_err port, no extra states, write latency 2 cycles.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - state enum (IDLE, WR, RD_ADDR, RD_CAP, FILL, VRD_ADDR, VRD_CAP);
  - localparam DEPTH = 2**ADDR_W;
  - op encoding constants OP_RD = 0, OP_WR = 1.
- One natural sub-module: ram_fill_counter. It is an ADDR_W-bit up-counter with start, enable and terminal-count output, used by FILL.

Test Plan:
- Reset: hold clear = 0 with req_valid = 1 → all outputs 0 and no ram_r_w pulse. After release → req_ready = 1 next cycle.
- Write/read: write addr 1 data 8'hA5, then read addr 1 → exactly one ram_r_w = 1 cycle with ram_addr = 1, ram_din = A5. Then rsp_valid one cycle, rsp_rdata = A5, 3 cycles after the read accept.
- Fill: fill_start with fill_value = 8'h3C (ADDR_W = 1) → 2 write cycles at addr 0 and addr 1, busy high 2 cycles. Reads of addr 0 and addr 1 both return 3C.
- Priority: fill_start and req_valid together in IDLE → req_ready = 0, FILL entered, request stalls. It is accepted in the first IDLE cycle after fill completes.
- Abort: assert clear during RD_ADDR → rsp_valid never pulses, state IDLE. A subsequent read of a previously written 8'h5A returns 5A.
- Verify (with RAM_ACCESS_CTRL_VERIFY_EN): RAM model forces bit 0 stuck-at-0, write 8'hFF → verify_err = 1 at VRD_CAP+1 and stays 1 until reset.
